// File: rtl/core_v_mcu_pkg.sv
// ---------------------------------------------------------------------------
// core_v_mcu_pkg
// Shared types and default constants for the core_v_mcu subsystem.
// The cpu_boot_ctrl defaults live here so that cpu_subsystem integration
// can reference the same values when it overrides or checks parameters.
// ---------------------------------------------------------------------------
package core_v_mcu_pkg;

   // Boot sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,  // core held in reset, waiting for boot_req_i
      HOLD  = 2'd1,  // core held in reset for RST_HOLD_CYCLES
      RUN   = 2'd2,  // core released, watchdog active
      FAULT = 2'd3   // retries exhausted, core held in reset
   } cpu_boot_state_e;

   // Default parameter values for cpu_boot_ctrl.
   localparam int unsigned CPU_BOOT_RST_HOLD_CYCLES = 16;
   localparam int unsigned CPU_BOOT_WDT_CYCLES      = 1048576;
   localparam bit          CPU_BOOT_WDT_EN          = 1'b1;
   localparam int unsigned CPU_BOOT_MAX_RETRIES     = 3;

endpackage : core_v_mcu_pkg

// File: rtl/cpu_boot_wdt.sv
// ---------------------------------------------------------------------------
// cpu_boot_wdt
// Heartbeat watchdog for the CPU boot sequencer. Counts consecutive enabled
// cycles without a kick and flags a trip on the cycle where the count has
// reached WDT_CYCLES-1 and no kick arrives.
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset
//   enable  in   count this cycle (core running and watchdog built in)
//   clear   in   force the counter to zero (core not running)
//   kick    in   heartbeat; clears the counter and suppresses a trip
//   trip    out  combinational trip flag for the current cycle
// ---------------------------------------------------------------------------
module cpu_boot_wdt
   import core_v_mcu_pkg::*;
#(
   parameter int unsigned WDT_CYCLES = CPU_BOOT_WDT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable,
   input  logic clear,
   input  logic kick,
   output logic trip
);

   localparam int unsigned CNT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // A kick on the terminal cycle wins over the trip.
   assign trip = enable && !kick && (cnt_q == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear || kick || trip) begin
         cnt_q <= '0;
      end else if (enable) begin
         // Never reaches past CNT_LAST: the terminal cycle either trips or is
         // kicked, and both clear the counter.
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule : cpu_boot_wdt

// File: rtl/cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_boot_ctrl
// Reset and boot sequencer for the CVA6 CPU subsystem. Holds the core in
// reset until a boot request, releases it after RST_HOLD_CYCLES, re-boots it
// on watchdog trips and latches a sticky fault after MAX_RETRIES trips.
//
// Ports:
//   clk_i           in   clock (single domain)
//   rst_i           in   synchronous active-high reset
//   boot_req_i      in   start boot (IDLE only)
//   boot_addr_i     in   64-bit boot address, sampled with boot_req_i
//   soft_rst_req_i  in   re-boot request (RUN only)
//   halt_req_i      in   return to IDLE from any state
//   heartbeat_i     in   watchdog kick
//   cpu_rst_no      out  CPU reset, active-low, registered; drives rst_ni
//   boot_addr_o     out  latched boot address
//   cpu_running_o   out  high in RUN
//   wdt_trip_o      out  one-cycle pulse per watchdog trip
//   retry_cnt_o     out  watchdog trips since the last accepted boot_req_i
//   fault_o         out  sticky fault, retries exhausted
// ---------------------------------------------------------------------------
module cpu_boot_ctrl
   import core_v_mcu_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYCLES = CPU_BOOT_RST_HOLD_CYCLES,
   parameter int unsigned WDT_CYCLES      = CPU_BOOT_WDT_CYCLES,
   parameter bit          WDT_EN          = CPU_BOOT_WDT_EN,
   parameter int unsigned MAX_RETRIES     = CPU_BOOT_MAX_RETRIES
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               boot_req_i,
   input  logic [63:0]                        boot_addr_i,
   input  logic                               soft_rst_req_i,
   input  logic                               halt_req_i,
   input  logic                               heartbeat_i,
   output logic                               cpu_rst_no,
   output logic [63:0]                        boot_addr_o,
   output logic                               cpu_running_o,
   output logic                               wdt_trip_o,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
   output logic                               fault_o
);

   localparam int unsigned HOLD_W  = $clog2(RST_HOLD_CYCLES + 1);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   cpu_boot_state_e     state_q, state_d;
   logic [HOLD_W-1:0]   hold_cnt_q;
   logic [RETRY_W-1:0]  retry_d;
   logic [RETRY_W-1:0]  retry_inc;
   logic                addr_latch;
   logic                trip_taken;
   logic                wdt_trip;

   cpu_boot_wdt #(
      .WDT_CYCLES (WDT_CYCLES)
   ) u_wdt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .enable (WDT_EN && (state_q == RUN)),
      .clear  (state_q != RUN),
      .kick   (heartbeat_i),
      .trip   (wdt_trip)
   );

   assign retry_inc = retry_cnt_o + RETRY_W'(1);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      retry_d    = retry_cnt_o;
      addr_latch = 1'b0;
      trip_taken = 1'b0;

      if (halt_req_i) begin
         state_d = IDLE;
         retry_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (boot_req_i) begin
                  state_d    = HOLD;
                  retry_d    = '0;
                  addr_latch = 1'b1;
               end
            end
            HOLD: begin
               if (hold_cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
               // Soft reset outranks both heartbeat and trip.
               if (soft_rst_req_i) begin
                  state_d = HOLD;
               end else if (wdt_trip) begin
                  trip_taken = 1'b1;
                  retry_d    = retry_inc;
                  state_d    = (retry_inc == RETRY_MAX) ? FAULT : HOLD;
               end
            end
            FAULT: ;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state, so they describe the state
   // the block is in during the current cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         hold_cnt_q    <= '0;
         retry_cnt_o   <= '0;
         boot_addr_o   <= '0;
         cpu_rst_no    <= 1'b0;
         cpu_running_o <= 1'b0;
         wdt_trip_o    <= 1'b0;
         fault_o       <= 1'b0;
      end else begin
         state_q       <= state_d;
         // Held at zero outside HOLD, so every HOLD entry starts from zero.
         hold_cnt_q    <= (state_q == HOLD) ? hold_cnt_q + HOLD_W'(1) : '0;
         retry_cnt_o   <= retry_d;
         if (addr_latch) boot_addr_o <= boot_addr_i;
         cpu_rst_no    <= (state_d == RUN);
         cpu_running_o <= (state_d == RUN);
         wdt_trip_o    <= trip_taken;
         fault_o       <= (state_d == FAULT);
      end
   end

endmodule : cpu_boot_ctrl

// File: tb/tb_cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_boot_ctrl
// Directed bench for cpu_boot_ctrl with RST_HOLD_CYCLES=4, WDT_CYCLES=8,
// MAX_RETRIES=2. A second instance built with WDT_EN=0 shares the control
// inputs but never sees a heartbeat.
// ---------------------------------------------------------------------------
module tb_cpu_boot_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        boot_req;
   logic [63:0] boot_addr;
   logic        soft_rst_req;
   logic        halt_req;
   logic        heartbeat;

   logic        cpu_rst_n,  cpu_rst_n2;
   logic [63:0] boot_addr_q, boot_addr_q2;
   logic        running,    running2;
   logic        trip,       trip2;
   logic [1:0]  retry,      retry2;
   logic        fault,      fault2;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   cpu_boot_ctrl #(
      .RST_HOLD_CYCLES (4),
      .WDT_CYCLES      (8),
      .WDT_EN          (1'b1),
      .MAX_RETRIES     (2)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .boot_req_i     (boot_req),
      .boot_addr_i    (boot_addr),
      .soft_rst_req_i (soft_rst_req),
      .halt_req_i     (halt_req),
      .heartbeat_i    (heartbeat),
      .cpu_rst_no     (cpu_rst_n),
      .boot_addr_o    (boot_addr_q),
      .cpu_running_o  (running),
      .wdt_trip_o     (trip),
      .retry_cnt_o    (retry),
      .fault_o        (fault)
   );

   cpu_boot_ctrl #(
      .RST_HOLD_CYCLES (4),
      .WDT_CYCLES      (8),
      .WDT_EN          (1'b0),
      .MAX_RETRIES     (2)
   ) dut_nowdt (
      .clk_i          (clk),
      .rst_i          (rst),
      .boot_req_i     (boot_req),
      .boot_addr_i    (boot_addr),
      .soft_rst_req_i (soft_rst_req),
      .halt_req_i     (halt_req),
      .heartbeat_i    (1'b0),
      .cpu_rst_no     (cpu_rst_n2),
      .boot_addr_o    (boot_addr_q2),
      .cpu_running_o  (running2),
      .wdt_trip_o     (trip2),
      .retry_cnt_o    (retry2),
      .fault_o        (fault2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs set afterwards are sampled at the next edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".rst_n"},   cpu_rst_n,   1'b0);
      check({tag, ".addr"},    boot_addr_q, 64'h0);
      check({tag, ".running"}, running,     1'b0);
      check({tag, ".trip"},    trip,        1'b0);
      check({tag, ".retry"},   retry,       2'd0);
      check({tag, ".fault"},   fault,       1'b0);
   endtask

   // Assert boot_req for one edge with the given address, then scramble the
   // address so a late latch would show up.
   task automatic do_boot(input logic [63:0] addr);
      boot_req  = 1'b1;
      boot_addr = addr;
      tick();
      boot_req  = 1'b0;
      boot_addr = 64'hDEAD_BEEF_0BAD_F00D;
   endtask

   logic seen_trip;

   initial begin
      rst = 1'b1; boot_req = 1'b0; boot_addr = '0;
      soft_rst_req = 1'b0; halt_req = 1'b0; heartbeat = 1'b0;

      // Reset state.
      tick(2);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();
      check("idle.rst_n", cpu_rst_n, 1'b0);

      // Boot: low for 4 cycles after the accepting edge, released in the 5th.
      do_boot(64'h8000_0000);
      check("boot.addr", boot_addr_q, 64'h8000_0000);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("boot.hold%0d.rst_n", i), cpu_rst_n, 1'b0);
         check($sformatf("boot.hold%0d.run", i),   running,   1'b0);
         tick();
      end
      check("boot.release.rst_n", cpu_rst_n, 1'b1);
      check("boot.release.run",   running,   1'b1);

      // Heartbeat every 7th RUN cycle for 100 cycles: never trips.
      seen_trip = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         heartbeat = (c % 7 == 0);
         tick();
         seen_trip |= trip;
      end
      check("hb7.trip",  seen_trip, 1'b0);
      check("hb7.retry", retry,     2'd0);
      check("hb7.run",   running,   1'b1);

      // Heartbeat exactly on counter==7 suppresses the trip.
      heartbeat = 1'b1; tick();
      heartbeat = 1'b0; tick(7);
      heartbeat = 1'b1; tick();
      heartbeat = 1'b0;
      check("hbterm.trip", trip,    1'b0);
      check("hbterm.run",  running, 1'b1);

      // No heartbeat: counter is 0 in the current cycle; trip in 8th cycle.
      tick(7);
      check("trip1.pre.trip", trip,    1'b0);
      check("trip1.pre.run",  running, 1'b1);
      tick();
      check("trip1.pulse", trip,      1'b1);
      check("trip1.rst_n", cpu_rst_n, 1'b0);
      check("trip1.retry", retry,     2'd1);
      check("trip1.fault", fault,     1'b0);
      tick();
      check("trip1.once",  trip,      1'b0);
      tick(2);
      check("trip1.hold4.rst_n", cpu_rst_n, 1'b0);
      tick();
      check("trip1.reboot.rst_n", cpu_rst_n, 1'b1);
      check("trip1.reboot.run",   running,   1'b1);

      // Second trip exhausts retries.
      tick(8);
      check("trip2.pulse", trip,      1'b1);
      check("trip2.fault", fault,     1'b1);
      check("trip2.retry", retry,     2'd2);
      check("trip2.rst_n", cpu_rst_n, 1'b0);
      do_boot(64'h5555);
      tick(6);
      check("fault.sticky",   fault,       1'b1);
      check("fault.rst_n",    cpu_rst_n,   1'b0);
      check("fault.addr",     boot_addr_q, 64'h8000_0000);
      check("fault.retry",    retry,       2'd2);
      check("fault.trip",     trip,        1'b0);

      // Halt out of FAULT.
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      check("halt.fault", fault,       1'b0);
      check("halt.retry", retry,       2'd0);
      check("halt.rst_n", cpu_rst_n,   1'b0);
      check("halt.run",   running,     1'b0);
      check("halt.addr",  boot_addr_q, 64'h8000_0000);

      // New boot with a different address.
      do_boot(64'h1000);
      check("boot2.addr", boot_addr_q, 64'h1000);
      tick(4);
      check("boot2.run", running, 1'b1);

      // One trip so retry_cnt is nonzero before the soft reset.
      tick(8);
      check("trip3.pulse", trip,  1'b1);
      check("trip3.retry", retry, 2'd1);
      tick(4);
      check("trip3.reboot.run", running, 1'b1);
      tick(2);

      // Soft reset with heartbeat in the same cycle; boot_req during HOLD.
      soft_rst_req = 1'b1; heartbeat = 1'b1; tick();
      soft_rst_req = 1'b0; heartbeat = 1'b0;
      check("soft.rst_n", cpu_rst_n, 1'b0);
      check("soft.run",   running,   1'b0);
      check("soft.retry", retry,     2'd1);
      do_boot(64'hABCD);
      check("soft.addr",  boot_addr_q, 64'h1000);
      check("soft.retry2", retry,      2'd1);
      tick(2);
      check("soft.hold4.rst_n", cpu_rst_n, 1'b0);
      tick();
      check("soft.release.rst_n", cpu_rst_n, 1'b1);

      // Soft reset on the terminal watchdog cycle wins over the trip.
      tick(7);
      soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
      check("softtrip.trip",  trip,      1'b0);
      check("softtrip.retry", retry,     2'd1);
      check("softtrip.rst_n", cpu_rst_n, 1'b0);
      tick(4);
      check("softtrip.release.run", running, 1'b1);

      // Soft reset outside RUN is ignored.
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      soft_rst_req = 1'b1; tick(3); soft_rst_req = 1'b0;
      check("softidle.rst_n", cpu_rst_n, 1'b0);
      do_boot(64'h3000);
      tick(4);
      check("boot3.run", running, 1'b1);
      tick(2);

      // Synchronous reset mid-RUN.
      rst = 1'b1; tick(); rst = 1'b0;
      check_reset_outputs("midrst");
      tick(3);
      check("midrst.idle.rst_n", cpu_rst_n, 1'b0);

      // WDT_EN=0 instance: 1000 heartbeat-free RUN cycles with no trip.
      do_boot(64'h2000);
      tick(4);
      check("nowdt.run.start", running2, 1'b1);
      seen_trip = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         seen_trip |= trip2;
      end
      check("nowdt.trip",  seen_trip,  1'b0);
      check("nowdt.retry", retry2,     2'd0);
      check("nowdt.run",   running2,   1'b1);
      check("nowdt.rst_n", cpu_rst_n2, 1'b1);
      check("nowdt.fault", fault2,     1'b0);
      check("nowdt.addr",  boot_addr_q2, 64'h2000);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule : tb_cpu_boot_ctrl

// File: doc/cpu_boot_ctrl.md
# cpu_boot_ctrl

Reset and boot sequencer for the CVA6 CPU subsystem. Owns the CPU's active-low reset and 64-bit boot address. Holds the core in reset until a boot request arrives, then releases it after a fixed hold interval. While the core runs, a heartbeat watchdog re-boots it on a hang, and the block latches a sticky fault after a bounded number of retries.

## Interface
Parameters:
- RST_HOLD_CYCLES, 16: cycles `cpu_rst_no` stays low per boot attempt; must be ≥1.
- WDT_CYCLES, 1048576: consecutive heartbeat-free RUN cycles that trip the watchdog; must be ≥2.
- WDT_EN, 1: 0 disables the watchdog entirely.
- MAX_RETRIES, 3: watchdog trips tolerated before FAULT; must be ≥1.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; **synchronous, active-high**.
- boot_req_i  in  1  start boot; honoured only in IDLE.
- boot_addr_i  in  64  boot address, sampled on the accepted boot_req_i cycle.
- soft_rst_req_i  in  1  re-boot request; honoured only in RUN.
- halt_req_i  in  1  return to IDLE from any state.
- heartbeat_i  in  1  watchdog kick.
- cpu_rst_no  out  1  CPU reset, active-low, registered.
- boot_addr_o  out  64  latched boot address to the CPU.
- cpu_running_o  out  1  high in RUN.
- wdt_trip_o  out  1  one-cycle pulse per watchdog trip.
- retry_cnt_o  out  $clog2(MAX_RETRIES+1)  watchdog trips since last boot_req_i.
- fault_o  out  1  sticky; retries exhausted.

## Operation
States and what each one drives:
- IDLE: `cpu_rst_no`=0.
- HOLD: `cpu_rst_no`=0; hold counter runs.
- RUN: `cpu_rst_no`=1; watchdog counter runs.
- FAULT: `cpu_rst_no`=0; `fault_o`=1.

Transitions:
- IDLE → HOLD on boot_req_i.
  - Latch boot_addr_i into boot_addr_o.
  - Clear retry_cnt.
  - Clear the hold counter.
- HOLD → RUN after exactly RST_HOLD_CYCLES cycles in HOLD. Clear the watchdog counter on entry to RUN.
- RUN → HOLD on soft_rst_req_i. retry_cnt is unchanged; boot_addr_o is unchanged.
- RUN watchdog:
  - Counter increments each RUN cycle with heartbeat_i=0.
  - heartbeat_i=1 clears the counter to 0.
  - A cycle with heartbeat_i=0 and counter==WDT_CYCLES-1 is a trip.
  - On a trip, retry_cnt increments, then: new value <MAX_RETRIES → HOLD; new value ==MAX_RETRIES → FAULT.
- FAULT: stays until halt_req_i or rst_i; boot_req_i is ignored.
- Any state → IDLE on halt_req_i. Clears retry_cnt and fault_o; boot_addr_o keeps its value.

Priority within one cycle: rst_i > halt_req_i > soft_rst_req_i > heartbeat_i > trip. A heartbeat on the terminal cycle suppresses the trip.

Ignored inputs and counter limits:
- boot_req_i outside IDLE and soft_rst_req_i outside RUN are ignored; they are not queued.
- boot_addr_i changes after the latch cycle have no effect.
- With WDT_EN=0: no trips, wdt_trip_o stays 0, retry_cnt stays 0.
- Counters saturate or clear as described; they never wrap.

## Timing
- Reset values:
  - state=IDLE
  - cpu_rst_no=0, boot_addr_o=0, cpu_running_o=0
  - wdt_trip_o=0, retry_cnt_o=0, fault_o=0
- rst_i asserted mid-RUN: cpu_rst_no=0 from the next edge.
- All outputs are registered and reflect the state of the current cycle.
- boot_req_i accepted at edge t:
  - cpu_rst_no is low for cycles t+1 … t+RST_HOLD_CYCLES.
  - cpu_rst_no=1 and cpu_running_o=1 from cycle t+RST_HOLD_CYCLES+1.
- Trip detected in cycle r:
  - wdt_trip_o=1 in cycle r+1 only.
  - In r+1, state=HOLD (or FAULT), cpu_rst_no=0, and retry_cnt_o is already updated.
- soft_rst_req_i in cycle r: cpu_rst_no=0 from cycle r+1; the next release is after RST_HOLD_CYCLES cycles.
- Watchdog with no heartbeat: the trip occurs in the WDT_CYCLES-th consecutive RUN cycle, counting the RUN entry cycle as the 1st.

## Structure
- Add `cpu_boot_state_e` (IDLE, HOLD, RUN, FAULT) to `core_v_mcu_pkg`.
- Default parameter constants also go in `core_v_mcu_pkg`, so cpu_subsystem integration can reference them.
- Use one sub-module, `cpu_boot_wdt`, holding the watchdog counter and trip compare:
  - inputs: enable, clear, kick
  - output: trip
  - Instantiate it once.
- The hold counter stays inline.
- `cpu_rst_no` drives cpu_subsystem `rst_ni` directly; no further synchronisation is needed (same clock).

## Test plan
Bench parameters: RST_HOLD_CYCLES=4, WDT_CYCLES=8, MAX_RETRIES=2.
- Boot: boot_req_i=1 with boot_addr_i=0x8000_0000 at edge t → boot_addr_o=0x8000_0000 and cpu_rst_no=0 through t+4; cpu_rst_no=1 and cpu_running_o=1 at t+5.
- Heartbeat every 7 cycles for 100 cycles in RUN → no wdt_trip_o, retry_cnt_o=0. Heartbeat exactly on counter==7 → no trip.
- No heartbeat → trip in the 8th RUN cycle, wdt_trip_o pulses once, retry_cnt_o=1, re-boot after 4 cycles. Second trip → FAULT: fault_o=1, cpu_rst_no=0, boot_req_i ignored.
- halt_req_i in FAULT → IDLE, fault_o=0, retry_cnt_o=0. A new boot_req_i with 0x1000 → boot_addr_o=0x1000.
- soft_rst_req_i and heartbeat_i together in RUN → HOLD for 4 cycles, retry_cnt_o unchanged. boot_req_i with a different address during HOLD → boot_addr_o unchanged.
- rst_i mid-RUN → next cycle: all outputs at reset values, state IDLE. WDT_EN=0 build → 1000 heartbeat-free RUN cycles with no trip.
